vga_scan_reader: RTL

//  VGA scan-out stage, downstream consumer of the SRAM manager's read port. Generates
//  640x480@60 timing from the system clock via a pixel-enable divider, drives the

---
 rtl/vga_scan_reader_if.sv | 37 +++
 rtl/vga_scan_reader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vga_scan_reader_if.sv
// Frame-buffer read port towards the SRAM manager and the DAC-side pins of the
// VGA scan-out stage.
interface vga_scan_reader_if;
  logic [19:0] read_Address;
  logic [15:0] read_output;
  logic        Hsync;
  logic        Vsync;
  logic [4:0]  VGA_R;
  logic [5:0]  VGA_G;
  logic [4:0]  VGA_B;
  logic        Disp_En;
  logic        Frame_Start;

  modport master (
    output read_Address,
    input  read_output,
    output Hsync,
    output Vsync,
    output VGA_R,
    output VGA_G,
    output VGA_B,
    output Disp_En,
    output Frame_Start
  );

  modport slave (
    input  read_Address,
    output read_output,
    input  Hsync,
    input  Vsync,
    input  VGA_R,
    input  VGA_G,
    input  VGA_B,
    input  Disp_En,
    input  Frame_Start
  );
endinterface

// File: rtl/vga_scan_reader.sv
// VGA scan-out: pixel-enable divider, h/v raster counters, linear frame-buffer
// address generation, phase-safe sampling of the returned RGB565 word and a
// two-stage pipeline that keeps colour, syncs and Disp_En aligned on the pins.
module vga_scan_reader #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          CLK_DIV   = 4,
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  vga_scan_reader_if.master bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = $clog2(CLK_DIV);

  // Colour is forced to black whenever the pixel is outside the visible area.
  function automatic logic [15:0] blank_pixel(input logic en, input logic [15:0] px);
    return en ? px : 16'h0000;
  endfunction

  // Converts an internal "sync asserted" flag to the pin level.
  function automatic logic sync_level(input logic asserted);
    return asserted ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   smp_q, smp_d;
  logic          vld_p0_q, vld_p0_d;
  logic          hs_p0_q, hs_p0_d;
  logic          vs_p0_q, vs_p0_d;
  logic          vld_p1_q, vld_p1_d;
  logic          hsync_p1_q, hsync_p1_d;
  logic          vsync_p1_q, vsync_p1_d;
  logic [15:0]   rgb_p1_q, rgb_p1_d;
  logic          fs_q, fs_d;

  logic pix_tick, smp_en, h_last, v_last, frame_last, active, hs_on, vs_on;

  assign pix_tick   = (div_q == DW'(CLK_DIV - 1));
  // Second clock of the following pixel period: the SRAM manager has had a full
  // round with the held address whatever its phase, and has not yet replaced it.
  assign smp_en     = (div_q == DW'(1));
  assign h_last     = (h_q == HW'(H_TOTAL - 1));
  assign v_last     = (v_q == VW'(V_TOTAL - 1));
  assign frame_last = h_last && v_last;
  assign active     = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
  assign hs_on      = (h_q >= HW'(HS_START)) && (h_q < HW'(HS_END));
  assign vs_on      = (v_q >= VW'(VS_START)) && (v_q < VW'(VS_END));

  // Next-state logic: everything except the divider and sampler moves on pix_tick.
  always_comb begin
    div_d      = pix_tick ? '0 : div_q + DW'(1);
    h_d        = h_q;
    v_d        = v_q;
    addr_d     = addr_q;
    smp_d      = smp_en ? bus.read_output : smp_q;
    vld_p0_d   = vld_p0_q;
    hs_p0_d    = hs_p0_q;
    vs_p0_d    = vs_p0_q;
    vld_p1_d   = vld_p1_q;
    hsync_p1_d = hsync_p1_q;
    vsync_p1_d = vsync_p1_q;
    rgb_p1_d   = rgb_p1_q;
    fs_d       = 1'b0;
    if (pix_tick) begin
      h_d = h_last ? '0 : h_q + HW'(1);
      if (h_last) begin
        v_d = v_last ? '0 : v_q + VW'(1);
      end
      if (frame_last) begin
        addr_d = BASE_ADDR;
      end else if (active) begin
        addr_d = addr_q + 20'd1;
      end
      // Stage 0: raster attributes of the pixel whose address is leaving the bus
      vld_p0_d   = active;
      hs_p0_d    = hs_on;
      vs_p0_d    = vs_on;
      // Stage 1: attributes joined with the sampled word, drives the pins
      vld_p1_d   = vld_p0_q;
      hsync_p1_d = sync_level(hs_p0_q);
      vsync_p1_d = sync_level(vs_p0_q);
      rgb_p1_d   = blank_pixel(vld_p0_q, smp_q);
      fs_d       = frame_last;
    end
  end

  // State and pipeline registers; reset restarts the raster at (0,0) immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      addr_q     <= BASE_ADDR;
      smp_q      <= '0;
      vld_p0_q   <= 1'b0;
      hs_p0_q    <= 1'b0;
      vs_p0_q    <= 1'b0;
      vld_p1_q   <= 1'b0;
      hsync_p1_q <= ~SYNC_POL;
      vsync_p1_q <= ~SYNC_POL;
      rgb_p1_q   <= '0;
      fs_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      addr_q     <= addr_d;
      smp_q      <= smp_d;
      vld_p0_q   <= vld_p0_d;
      hs_p0_q    <= hs_p0_d;
      vs_p0_q    <= vs_p0_d;
      vld_p1_q   <= vld_p1_d;
      hsync_p1_q <= hsync_p1_d;
      vsync_p1_q <= vsync_p1_d;
      rgb_p1_q   <= rgb_p1_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.read_Address = addr_q;
  assign bus.Hsync        = hsync_p1_q;
  assign bus.Vsync        = vsync_p1_q;
  assign bus.VGA_R        = rgb_p1_q[15:11];
  assign bus.VGA_G        = rgb_p1_q[10:5];
  assign bus.VGA_B        = rgb_p1_q[4:0];
  assign bus.Disp_En      = vld_p1_q;
  assign bus.Frame_Start  = fs_q;
endmodule
